// File: rtl/cgra_cond_pkg.sv
// Shared definitions for the CGRA condition-test arbiter.
//   NUM_REQ_DEFAULT : default requester count
//   id_width()      : requester-ID width for a given requester count
//   cond_cfg_t      : per-requester checker configuration record
package cgra_cond_pkg;

  localparam int NUM_REQ_DEFAULT = 4;

  // Never returns 0, so a degenerate single-requester build still has a usable ID field.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [2:0] valid_bits;
    logic       exclude_lsb;
  } cond_cfg_t;

endpackage

// File: rtl/validNotZero.sv
// Combinational condition checker: reports whether the masked operand is non-zero.
// The mask keeps the low valid_bits_i bits of the operand, and bit 0 is also
// dropped when exclude_lsb_i is set.
//   data_i        : operand
//   valid_bits_i  : number of low operand bits that take part in the test (0..7)
//   exclude_lsb_i : drop bit 0 from the test
//   nz_o          : 1 when (data_i & mask) != 0
module validNotZero #(
  parameter int DATA_SIZE = 8
) (
  input  logic [DATA_SIZE-1:0] data_i,
  input  logic [2:0]           valid_bits_i,
  input  logic                 exclude_lsb_i,
  output logic                 nz_o
);

  logic [DATA_SIZE-1:0] mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i < DATA_SIZE; i++) begin
      mask[i] = (32'(valid_bits_i) > i);
    end
    if (exclude_lsb_i) mask[0] = 1'b0;
    nz_o = |(data_i & mask);
  end

endmodule

// File: rtl/cond_test_arbiter.sv
// Round-robin arbiter sharing one validNotZero checker among NUM_REQ requesters.
// Each requester has a config slot written through the cfg_* port. One request is
// granted per cycle and its result is registered on a back-pressured result channel
// tagged with the requester ID.
//   clk, rst_n          : clock, async active-low reset
//   cfg_we/idx/...      : config slot write port
//   req_valid/req_data  : per-requester requests and operands
//   req_ready           : one-hot grant (zero when the result slot is occupied)
//   res_valid/id/nz     : registered result
//   res_ready           : consumer accepts the result
module cond_test_arbiter
  import cgra_cond_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int NUM_REQ   = NUM_REQ_DEFAULT,
  parameter int ID_W      = id_width(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [ID_W-1:0]              cfg_idx,
  input  logic [2:0]                   cfg_valid_bits,
  input  logic                         cfg_exclude_lsb,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         res_valid,
  output logic [ID_W-1:0]              res_id,
  output logic                         res_nz,
  input  logic                         res_ready
);

  cond_cfg_t cfg_q [NUM_REQ];

  logic            res_valid_q, res_valid_d;
  logic [ID_W-1:0] res_id_q, res_id_d;
  logic            res_nz_q, res_nz_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      gnt_idx;
  logic                 found;
  logic                 slot_free;
  logic                 accept;

  cond_cfg_t            sel_cfg;
  logic [DATA_SIZE-1:0] sel_data;
  logic                 chk_nz;

  // Round-robin: rotate so rr_ptr sits at bit 0, find the first set bit,
  // then map the offset back to an absolute requester index.
  always_comb begin
    req_dbl = {req_valid, req_valid};
    req_rot = req_dbl[rr_ptr_q +: NUM_REQ];
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_rot[k]) begin
        found   = 1'b1;
        gnt_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
    grant = '0;
    if (found) grant[gnt_idx] = 1'b1;
  end

  assign slot_free = !res_valid_q || res_ready;
  // rst_n gating keeps the grant quiet during reset even though the slot reads free.
  assign req_ready = (rst_n && slot_free) ? grant : '0;
  assign accept    = |(req_valid & req_ready);

  assign sel_data = req_data[gnt_idx*DATA_SIZE +: DATA_SIZE];
  assign sel_cfg  = cfg_q[gnt_idx];

  validNotZero #(
    .DATA_SIZE(DATA_SIZE)
  ) u_vnz (
    .data_i       (sel_data),
    .valid_bits_i (sel_cfg.valid_bits),
    .exclude_lsb_i(sel_cfg.exclude_lsb),
    .nz_o         (chk_nz)
  );

  always_comb begin
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_nz_d    = res_nz_q;
    rr_ptr_d    = rr_ptr_q;
    if (slot_free) begin
      res_valid_d = accept;
      if (accept) begin
        res_id_d = gnt_idx;
        res_nz_d = chk_nz;
        rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_nz_q    <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_nz_q    <= res_nz_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // The checker above reads the pre-edge slot contents, so a write coinciding
  // with an accept of the same slot only affects later accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cfg_q[i] <= '0;
    end else if (cfg_we && (int'(cfg_idx) < NUM_REQ)) begin
      cfg_q[cfg_idx] <= '{valid_bits: cfg_valid_bits, exclude_lsb: cfg_exclude_lsb};
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_nz    = res_nz_q;

endmodule
